ntt_mem_arbiter: RTL
====================

Name: ntt_mem_arbiter

Overview:
- Shared-memory arbiter sitting directly downstream of the per-core NTT engines' DMA ports.
- Accepts single-beat read/write requests from NUM_CORES engines over the req/gnt/valid handshake and serialises them round-robin onto one external memory port.
- Returns read data to the requesting core.
- One transaction outstanding at a time.

Parameters:
- NUM_CORES, 4, number of engine request ports (>=1, need not be a power of 2)
- IDX_W, 2, width of core index, $clog2(NUM_CORES) (min 1)
- ADDR_W, 48, byte address width
- DATA_W, 64, data word width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- core_req  in  NUM_CORES  per-core request, level, held until gnt seen
- core_we  in  NUM_CORES  per-core 1=write, 0=read
- core_addr  in  NUM_CORES*ADDR_W  flattened per-core byte address, core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  flattened per-core write data
- core_gnt  out  NUM_CORES  one-cycle grant pulse, one-hot
- core_valid  out  NUM_CORES  one-cycle read-response pulse, one-hot
- core_rdata  out  DATA_W  read data, broadcast to all cores, qualified by core_valid
- mem_req  out  1  external request, held until mem_ready
- mem_we  out  1  external write enable
- mem_addr  out  ADDR_W  external address
- mem_wdata  out  DATA_W  external write data
- mem_ready  in  1  external accept; transfer occurs on a cycle with mem_req&&mem_ready
- mem_rvalid  in  1  external read-data strobe
- mem_rdata  in  DATA_W  external read data
- busy  out  1  high whenever state != S_IDLE

Behaviour:
- Reset (async, rst_n=0) values:
  - All outputs 0; rr_ptr=0; state=S_IDLE.
  - A transaction in flight is dropped.
  - A mem_rvalid arriving after reset release is ignored.
- All outputs are registered.
- S_IDLE:
  - If any core_req is set, pick the winner: the first requesting index searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_CORES.
  - Latch idx, we, addr and wdata of the winner.
  - Set core_gnt[idx], mem_req, mem_we, mem_addr and mem_wdata.
  - Go to S_ISSUE.
- S_ISSUE:
  - core_gnt is high for exactly the first cycle of S_ISSUE, then 0.
  - mem_* fields are held stable until a cycle with mem_ready=1.
  - On that cycle: mem_req<=0; rr_ptr<=(idx==NUM_CORES-1)?0:idx+1.
  - Write: go to S_IDLE. No core_valid is ever generated for writes.
  - Read: go to S_WAIT.
- S_WAIT:
  - On mem_rvalid: core_rdata<=mem_rdata, core_valid[idx]<=1 (one cycle), go to S_RESP.
- S_RESP: core_valid<=0; go to S_IDLE.
- core_rdata holds its value until the next read response.
- Latency with zero-wait memory:
  - core_req seen at edge 0 -> core_gnt high in cycle 1, mem_req high in cycle 1.
  - Write done: back in S_IDLE at cycle 2.
  - Read with mem_rvalid in cycle 2: core_valid high in cycle 3.
- No re-grant while core_gnt is high. Cores drop core_req on the edge that samples gnt, and the FSM is never in S_IDLE during the gnt cycle, so a core cannot be double-granted.
- mem_rvalid outside S_WAIT is ignored. mem_ready outside S_ISSUE is ignored.
- core_req from non-winners is left pending, with no starvation: after serving idx, every other requester is served before idx again.
- A sole requester may be granted back-to-back.
- Address and data pass through unmodified. No alignment checking.

Optional Feature:
- Macro NTT_MEM_ARB_PERF_EN.
- Defined:
  - Adds output perf_grant_cnt, NUM_CORES*32 bits, flattened.
  - The counter for core i increments on each core_gnt[i] pulse, wraps at 2^32, and resets to 0.
  - Adds output perf_stall_cnt, 32 bits, which increments each cycle in S_ISSUE with mem_ready=0.
- Undefined: neither port exists and there is no counter logic. Behaviour is otherwise identical.

Decomposition:
- Package ntt_mem_pkg holds:
  - State encodings S_IDLE, S_ISSUE, S_WAIT, S_RESP (2-bit).
  - Default ADDR_W/DATA_W constants shared with the engines.
- One sub-module: ntt_rr_picker. It is combinational and takes req vector + rr_ptr -> winner idx + any_req. It is isolated for exhaustive unit test.

Test Plan:
- Reset: assert rst_n=0 mid-S_WAIT, then release and pulse mem_rvalid -> no core_valid, all outputs 0, rr_ptr=0, busy=0.
- Single read, zero-wait memory: core 1 reads addr 0x1000, mem_rvalid in cycle 2 with mem_rdata=0xDEADBEEF_00000001 -> core_gnt=4'b0010 in cycle 1; core_valid=4'b0010 in cycle 3; core_rdata=0xDEADBEEF_00000001.
- Write with backpressure: core 2 writes 0xAB at 0x40 with mem_ready low for 3 cycles -> mem_* stable for 4 cycles; no core_valid; S_IDLE at cycle 5 (perf_stall_cnt=3 when NTT_MEM_ARB_PERF_EN is defined).
- Fairness: all 4 cores hold reads continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3; each core_valid is routed to the matching core.
- Non-power-of-2: NUM_CORES=3, all requesting -> order 0,1,2,0; rr_ptr wraps from 2 to 0.
- Stray strobes: mem_rvalid pulsed in S_IDLE and mem_ready pulsed in S_WAIT -> ignored, no state change, no spurious core_valid.

Source files
------------

// File: rtl/ntt_mem_pkg.sv
// Shared definitions for the NTT engine memory arbiter: FSM state encoding and
// default address/data widths used by the engines' DMA ports.
package ntt_mem_pkg;

  localparam int NTT_ADDR_W = 48;
  localparam int NTT_DATA_W = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/ntt_rr_picker.sv
// Combinational round-robin picker: returns the first requesting index found
// when searching from i_ptr upwards, wrapping modulo NUM_CORES.
module ntt_rr_picker #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_CORES-1:0] i_req,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_any
);

  logic [IDX_W:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      w_cand = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NUM_CORES)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_CORES);
      end
      if (i_req[w_cand[IDX_W-1:0]]) begin
        o_idx = w_cand[IDX_W-1:0];
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ntt_mem_arbiter.sv
// Round-robin arbiter serialising single-beat NTT engine requests onto one
// memory port. Define NTT_MEM_ARB_PERF_EN to add grant/stall counters.
module ntt_mem_arbiter
  import ntt_mem_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  parameter int ADDR_W    = NTT_ADDR_W,
  parameter int DATA_W    = NTT_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_valid,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
`ifdef NTT_MEM_ARB_PERF_EN
  ,
  output logic [NUM_CORES*32-1:0]     perf_grant_cnt,
  output logic [31:0]                 perf_stall_cnt
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_rrPtr;
  logic [IDX_W-1:0] w_winIdx;
  logic             w_anyReq;
  logic [ADDR_W-1:0] w_addr  [NUM_CORES];
  logic [DATA_W-1:0] w_wdata [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign w_addr[g]  = core_addr[g*ADDR_W +: ADDR_W];
    assign w_wdata[g] = core_wdata[g*DATA_W +: DATA_W];
  end

  ntt_rr_picker #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_picker (
    .i_req (core_req),
    .i_ptr (r_rrPtr),
    .o_idx (w_winIdx),
    .o_any (w_anyReq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // mem_we doubles as the latched direction of the transaction in flight.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_anyReq) w_next = S_ISSUE;
      S_ISSUE: if (mem_ready) w_next = mem_we ? S_IDLE : S_WAIT;
      S_WAIT:  if (mem_rvalid) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_rrPtr    <= '0;
      core_gnt   <= '0;
      core_valid <= '0;
      core_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      core_gnt   <= '0;
      core_valid <= '0;
      busy       <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_idx     <= w_winIdx;
            core_gnt  <= NUM_CORES'(1) << w_winIdx;
            mem_req   <= 1'b1;
            mem_we    <= core_we[w_winIdx];
            mem_addr  <= w_addr[w_winIdx];
            mem_wdata <= w_wdata[w_winIdx];
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            r_rrPtr <= (r_idx == IDX_W'(NUM_CORES - 1)) ? '0 : r_idx + 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            core_rdata <= mem_rdata;
            core_valid <= NUM_CORES'(1) << r_idx;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NTT_MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_gnt[i]) begin
          perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
        end
      end
      if (r_state == S_ISSUE && !mem_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
